// File: rtl/imm_ext_arbiter.sv
// Two-port round-robin arbiter feeding a single-entry immediate-extension output stage.
// Build option: define IMM_EXT_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins).
module imm_ext_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [31:0] req0_instr,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_instr,
    output logic        req1_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_src,
    output logic [1:0]  out_mode
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high.
    // Requesters hold valid and the word stable until accepted; ready never feeds valid.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [1:0] MODE_SIGN   = 2'd0;
    localparam logic [1:0] MODE_ZERO   = 2'd1;
    localparam logic [1:0] MODE_UPPER  = 2'd2;
    localparam logic [1:0] MODE_BRANCH = 2'd3;

    state_t      r_state;
    logic [31:0] r_data;
    logic        r_src;
    logic [1:0]  r_mode;
`ifndef IMM_EXT_ARB_FIXED_PRIO_EN
    logic        r_last_grant;
`endif

    logic        w_slot_free;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_acc0;
    logic        w_acc1;
    logic        w_accept;
    logic [5:0]  w_sel_op;
    logic [15:0] w_sel_imm;
    logic [31:0] w_ext_data;
    logic [1:0]  w_ext_mode;
    logic        w_unused;

    // Middle instruction bits do not take part in immediate extension.
    assign w_unused = ^{req0_instr[25:16], req1_instr[25:16]};

    assign w_slot_free = (r_state == ST_EMPTY) | out_ready;

`ifdef IMM_EXT_ARB_FIXED_PRIO_EN
    assign w_gnt0 = req0_valid;
    assign w_gnt1 = req1_valid & ~req0_valid;
`else
    // On contention the port that did not win last time is served.
    assign w_gnt0 = req0_valid & (~req1_valid | r_last_grant);
    assign w_gnt1 = req1_valid & (~req0_valid | ~r_last_grant);
`endif

    assign req0_ready = w_slot_free & w_gnt0;
    assign req1_ready = w_slot_free & w_gnt1;

    assign w_acc0   = req0_valid & req0_ready;
    assign w_acc1   = req1_valid & req1_ready;
    assign w_accept = w_acc0 | w_acc1;

    assign w_sel_op  = w_acc1 ? req1_instr[31:26] : req0_instr[31:26];
    assign w_sel_imm = w_acc1 ? req1_instr[15:0]  : req0_instr[15:0];

    always_comb begin
        w_ext_mode = MODE_SIGN;
        w_ext_data = {{16{w_sel_imm[15]}}, w_sel_imm};
        case (w_sel_op)
            6'h0C, 6'h0D, 6'h0E: begin
                w_ext_mode = MODE_ZERO;
                w_ext_data = {16'h0000, w_sel_imm};
            end
            6'h0F: begin
                w_ext_mode = MODE_UPPER;
                w_ext_data = {w_sel_imm, 16'h0000};
            end
            6'h04, 6'h05: begin
                w_ext_mode = MODE_BRANCH;
                w_ext_data = {{14{w_sel_imm[15]}}, w_sel_imm, 2'b00};
            end
            default: begin
                w_ext_mode = MODE_SIGN;
                w_ext_data = {{16{w_sel_imm[15]}}, w_sel_imm};
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_data  <= 32'h0000_0000;
            r_src   <= 1'b0;
            r_mode  <= MODE_SIGN;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state <= ST_FULL;
                        r_data  <= w_ext_data;
                        r_src   <= w_acc1;
                        r_mode  <= w_ext_mode;
                    end
                end
                ST_FULL: begin
                    // Accept can only happen here when out_ready is high: back-to-back reload.
                    if (w_accept) begin
                        r_state <= ST_FULL;
                        r_data  <= w_ext_data;
                        r_src   <= w_acc1;
                        r_mode  <= w_ext_mode;
                    end else if (out_ready) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

`ifndef IMM_EXT_ARB_FIXED_PRIO_EN
    // Reset to 1 so that port 0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_acc1;
        end
    end
`endif

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_data;
    assign out_src   = r_src;
    assign out_mode  = r_mode;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed plus randomized bench for imm_ext_arbiter with a behavioural reference model.
module tb_imm_ext_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic [31:0] req0_instr;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_instr;
  logic        req1_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_src;
  logic [1:0]  out_mode;

  int n_cmp;
  int n_fail;

  // reference model state
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_src;
  logic [1:0]  m_mode;
  logic        m_last;
  logic        e_r0;
  logic        e_r1;

  imm_ext_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_instr (req0_instr),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_instr (req1_instr),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_mode   (out_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Spec-level extension rule: returns {mode, data}.
  function automatic logic [33:0] ref_ext(input logic [31:0] ins);
    int unsigned op;
    int s;
    int unsigned u;
    op = int'(ins[31:26]);
    u  = int'(ins[15:0]);
    s  = int'($signed(ins[15:0]));
    if (op == 12 || op == 13 || op == 14) return {2'd1, 32'(u)};
    if (op == 15) return {2'd2, 32'(u * 65536)};
    if (op == 4 || op == 5) return {2'd3, 32'(s * 4)};
    return {2'd0, 32'(s)};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 32'h0;
    m_src   = 1'b0;
    m_mode  = 2'd0;
    m_last  = 1'b1;
  endtask

  task automatic step(input logic v0, input logic [31:0] i0, input logic v1,
                      input logic [31:0] i1, input logic ordy);
    logic sf;
    logic g0;
    logic g1;
    logic [33:0] r;
    @(negedge clk);
    req0_valid = v0;
    req0_instr = i0;
    req1_valid = v1;
    req1_instr = i1;
    out_ready  = ordy;
    #1;
    sf = !m_valid || ordy;
`ifdef IMM_EXT_ARB_FIXED_PRIO_EN
    g0 = v0;
    g1 = v1 && !v0;
`else
    g0 = v0 && (!v1 || m_last);
    g1 = v1 && (!v0 || !m_last);
`endif
    e_r0 = sf && g0;
    e_r1 = sf && g1;
    chk("req0_ready", {31'b0, req0_ready}, {31'b0, e_r0});
    chk("req1_ready", {31'b0, req1_ready}, {31'b0, e_r1});
    @(posedge clk);
    #1;
    if (e_r0 || e_r1) begin
      r       = ref_ext(e_r0 ? i0 : i1);
      m_valid = 1'b1;
      m_data  = r[31:0];
      m_mode  = r[33:32];
      m_src   = e_r1;
      m_last  = e_r1;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk("out_data", out_data, m_data);
      chk("out_src", {31'b0, out_src}, {31'b0, m_src});
      chk("out_mode", {30'b0, out_mode}, {30'b0, m_mode});
    end
  endtask

  initial begin
    logic [1:0] exp_src [4];
    logic [5:0] ops [9];
    logic       h_v0;
    logic       h_v1;
    logic [31:0] h_i0;
    logic [31:0] h_i1;
    n_cmp  = 0;
    n_fail = 0;
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req0_instr = 32'h0;
    req1_valid = 1'b0;
    req1_instr = 32'h0;
    out_ready  = 1'b0;
    model_reset();

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_src", {31'b0, out_src}, 32'h0);
    chk("rst_out_mode", {30'b0, out_mode}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // extension modes
    step(1'b1, 32'h2008FFFC, 1'b0, 32'h0, 1'b1);
    chk("addi_data", out_data, 32'hFFFFFFFC);
    chk("addi_mode", {30'b0, out_mode}, 32'd0);
    chk("addi_src", {31'b0, out_src}, 32'd0);
    step(1'b0, 32'h0, 1'b1, 32'h35088000, 1'b1);
    chk("ori_data", out_data, 32'h00008000);
    chk("ori_mode", {30'b0, out_mode}, 32'd1);
    chk("ori_src", {31'b0, out_src}, 32'd1);
    step(1'b1, 32'h3C011234, 1'b0, 32'h0, 1'b1);
    chk("lui_data", out_data, 32'h12340000);
    chk("lui_mode", {30'b0, out_mode}, 32'd2);
    step(1'b1, 32'h1000FFFF, 1'b0, 32'h0, 1'b1);
    chk("beq_data", out_data, 32'hFFFFFFFC);
    chk("beq_mode", {30'b0, out_mode}, 32'd3);

    // backpressure while FULL, then release
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 32'h20080005, 1'b1, 32'h34090007, 1'b0);
      chk("bp_hold_data", out_data, 32'hFFFFFFFC);
      chk("bp_hold_mode", {30'b0, out_mode}, 32'd3);
    end
    step(1'b1, 32'h20080005, 1'b0, 32'h0, 1'b1);
    chk("bp_release_data", out_data, 32'h00000005);

    // asynchronous reset between edges while FULL
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("arst_out_data", out_data, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // contention, four cycles
`ifdef IMM_EXT_ARB_FIXED_PRIO_EN
    exp_src = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
    exp_src = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 32'h20080010 + 32'(k), 1'b1, 32'h20090020 + 32'(k), 1'b1);
      chk("cont_src", {31'b0, out_src}, {30'b0, exp_src[k]});
      chk("cont_valid", {31'b0, out_valid}, 32'h1);
    end
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

    // randomized traffic; pending offers are held until accepted
    ops = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h04, 6'h05, 6'h23, 6'h00};
    h_v0 = 1'b0;
    h_v1 = 1'b0;
    h_i0 = 32'h0;
    h_i1 = 32'h0;
    for (int n = 0; n < 1500; n++) begin
      if (!(h_v0 && !e_r0)) begin
        h_v0 = 1'($urandom_range(0, 1));
        h_i0 = {ops[$urandom_range(0, 8)], 26'($urandom)};
      end
      if (!(h_v1 && !e_r1)) begin
        h_v1 = 1'($urandom_range(0, 1));
        h_i1 = {ops[$urandom_range(0, 8)], 26'($urandom)};
      end
      step(h_v0, h_i0, h_v1, h_i1, ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_ext_arbiter.md
# imm_ext_arbiter

Round-robin arbiter and sequencer for the shared immediate-extension datapath. Two requesters offer a 32-bit instruction word over valid/ready handshakes:

- port 0: decode stage
- port 1: branch-target unit

The block grants one requester per cycle and decodes the opcode into an extension mode. It produces the registered 32-bit extended immediate on a single-entry output stage, with its own valid/ready handshake toward the ALU-operand and branch-adder consumers.

## Interface
Parameters:
- none (opcode encodings fixed to the MIPS-I subset used by the processor)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req0_valid  input  1  port 0 has an instruction
- req0_instr  input  32  port 0 instruction word
- req0_ready  output  1  port 0 accepted this cycle (combinational)
- req1_valid  input  1  port 1 has an instruction
- req1_instr  input  32  port 1 instruction word
- req1_ready  output  1  port 1 accepted this cycle (combinational)
- out_valid  output  1  out_* holds a result
- out_ready  input  1  consumer takes result this cycle
- out_data  output  32  extended immediate
- out_src  output  1  port that produced out_data
- out_mode  output  2  0 sign, 1 zero, 2 upper (LUI), 3 branch offset

## Operation
- Output state machine:
  - EMPTY (out_valid=0) ↔ FULL (out_valid=1).
  - slot_free = !out_valid | out_ready.
- Grant, combinational:
  - Only one port valid: that port.
  - Both valid: the port ≠ last_grant.
  - Neither valid: none.
  - reqN_ready = slot_free & granted(N). At most one ready high per cycle.
- Accept: reqN_valid & reqN_ready. On that edge:
  - Register result, out_src=N, out_valid=1.
  - last_grant=N.
- No accept and out_ready=1 while FULL → EMPTY.
- Accept while FULL with out_ready=1 → stays FULL with the new result (back-to-back, no bubble).
- Mode decode on opcode instr[31:26], imm = instr[15:0]:
  - 0x0C/0x0D/0x0E (ANDI/ORI/XORI): mode 1, {16'h0000, imm}
  - 0x0F (LUI): mode 2, {imm, 16'h0000}
  - 0x04/0x05 (BEQ/BNE): mode 3, {{14{imm[15]}}, imm, 2'b00}
  - all others: mode 0, {{16{imm[15]}}, imm}
- While FULL and out_ready=0:
  - out_* stable.
  - Both req*_ready low.
  - last_grant unchanged.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_src=0, out_mode=0.
  - last_grant=1, so port 0 wins the first contention.
- Reset assertion mid-operation clears any held result immediately, with no clock required. Consumers must not sample while rst_n=0.
- Latency: accept on edge N → out_valid/out_data visible after edge N, consumable at edge N+1.
- Throughput: one result per cycle with out_ready held high.
- Fairness: with both ports continuously valid and out_ready=1, grants alternate every cycle.
- Ready/valid dependence:
  - req*_ready depends combinationally on req*_valid, out_valid and out_ready.
  - out_valid depends on registers only.
  - Requesters must not make valid depend on ready.
- Requester holding valid without ready: the instruction must be held stable. The arbiter never drops an offered word.

## Configuration
- IMM_EXT_ARB_FIXED_PRIO_EN
  - Defined: fixed priority; port 0 always wins when both are valid, and last_grant is unused.
  - Undefined (default): round-robin as described above.
- Mode decode, latency and handshakes are identical in both builds.

## Test plan
- Sign extend: req0 0x2008FFFC (ADDI), out_ready=1 → next cycle out_valid=1, out_data=0xFFFFFFFC, mode 0, src 0.
- Zero extend and LUI:
  - req1 0x35088000 (ORI) → 0x00008000, mode 1, src 1.
  - 0x3C011234 (LUI) → 0x12340000, mode 2.
- Branch offset: req0 0x1000FFFF (BEQ) → 0xFFFFFFFC, mode 3.
- Contention: both valid for 4 cycles, out_ready=1 → out_src sequence 0,1,0,1 with no bubbles. With IMM_EXT_ARB_FIXED_PRIO_EN: 0,0,0,0, and req1_ready stays low.
- Backpressure: out_ready=0 for 3 cycles while FULL → out_data stable, req0_ready=req1_ready=0. Raising out_ready releases the pending request the same cycle.
- Async reset: rst_n low while FULL, between clock edges → out_valid=0 and out_data=0 before the next edge. After release, first contention grants port 0.
